// File: rtl/time_counter_param.sv
// time_counter_param
//   Divides clk to a one-second tick and keeps an hours:minutes:seconds count.
//   Counts up as a stopwatch or down as a countdown timer. It also has a
//   synchronous preset load and a sticky expiry flag.
//
// Ports
//   clk        system clock, all state on the rising edge
//   reset      asynchronous, active-low clear
//   startStop  level input; each rising edge toggles the run flag
//   mode       0 = count up, 1 = count down (applied at the next tick)
//   load       synchronous preset strobe
//   preset_s/m/h  preset values; minutes/seconds saturate at 59, hours at HOURS_MAX-1
//   seconds/minutes/hours  current time, binary
//   running    run flag
//   sec_tick   one-cycle pulse per counted second
//   expired    sticky countdown-complete flag (cleared by load or reset)
module time_counter_param #(
    parameter int TICKS_PER_SEC = 250,
    parameter int HOURS_MAX     = 24,
    parameter int W             = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         startStop,
    input  logic         mode,
    input  logic         load,
    input  logic [W-1:0] preset_s,
    input  logic [W-1:0] preset_m,
    input  logic [W-1:0] preset_h,
    output logic [W-1:0] seconds,
    output logic [W-1:0] minutes,
    output logic [W-1:0] hours,
    output logic         running,
    output logic         sec_tick,
    output logic         expired
);

    localparam int            PW       = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_TC = PW'(TICKS_PER_SEC - 1);
    localparam logic [W-1:0]  MS_TOP   = W'(59);
    localparam logic [W-1:0]  H_TOP    = W'(HOURS_MAX - 1);

    logic          ss_q, ss_d;
    logic          ss_prev_q, ss_prev_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [W-1:0]  sec_q, sec_d;
    logic [W-1:0]  min_q, min_d;
    logic [W-1:0]  hr_q, hr_d;
    logic          running_q, running_d;
    logic          sec_tick_q, sec_tick_d;
    logic          expired_q, expired_d;

    logic rise;
    logic tick;
    logic time_zero;
    logic next_zero;
    logic expire_now;

    always_comb begin
        ss_d       = startStop;
        ss_prev_d  = ss_q;
        rise       = ss_q & ~ss_prev_q;
        tick       = running_q && (presc_q == PRESC_TC);
        time_zero  = (sec_q == '0) && (min_q == '0) && (hr_q == '0);

        presc_d    = presc_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hr_d       = hr_q;
        running_d  = running_q;
        sec_tick_d = 1'b0;
        expired_d  = expired_q;
        expire_now = 1'b0;

        if (running_q) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (load) begin
            // Load wins over a tick landing in the same cycle.
            sec_d     = (preset_s > MS_TOP) ? MS_TOP : preset_s;
            min_d     = (preset_m > MS_TOP) ? MS_TOP : preset_m;
            hr_d      = (preset_h > H_TOP)  ? H_TOP  : preset_h;
            presc_d   = '0;
            expired_d = 1'b0;
        end else if (tick) begin
            sec_tick_d = 1'b1;
            if (!mode) begin
                if (sec_q == MS_TOP) begin
                    sec_d = '0;
                    if (min_q == MS_TOP) begin
                        min_d = '0;
                        hr_d  = (hr_q == H_TOP) ? '0 : hr_q + 1'b1;
                    end else begin
                        min_d = min_q + 1'b1;
                    end
                end else begin
                    sec_d = sec_q + 1'b1;
                end
            end else begin
                // Down count never goes below zero; reaching (or sitting at)
                // zero on a tick expires the timer.
                if (time_zero) begin
                    expire_now = 1'b1;
                end else if (sec_q != '0) begin
                    sec_d = sec_q - 1'b1;
                    if ((sec_q == W'(1)) && (min_q == '0) && (hr_q == '0)) begin
                        expire_now = 1'b1;
                    end
                end else begin
                    sec_d = MS_TOP;
                    if (min_q != '0) begin
                        min_d = min_q - 1'b1;
                    end else begin
                        min_d = MS_TOP;
                        hr_d  = hr_q - 1'b1;
                    end
                end
            end
        end

        next_zero = (sec_d == '0) && (min_d == '0) && (hr_d == '0);

        if (expire_now) begin
            expired_d = 1'b1;
            running_d = 1'b0;
        end else if (rise) begin
            // A start in down mode with nothing left to count is refused.
            if (running_q) begin
                running_d = 1'b0;
            end else if (!(mode && next_zero)) begin
                running_d = 1'b1;
            end
        end
    end

    // Edge-detect pair is deliberately not reset: it keeps tracking the pin
    // while reset is held, so a level already high at release is no edge.
    always_ff @(posedge clk) begin
        ss_q      <= ss_d;
        ss_prev_q <= ss_prev_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            presc_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hr_q       <= '0;
            running_q  <= 1'b0;
            sec_tick_q <= 1'b0;
            expired_q  <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hr_q       <= hr_d;
            running_q  <= running_d;
            sec_tick_q <= sec_tick_d;
            expired_q  <= expired_d;
        end
    end

    assign seconds  = sec_q;
    assign minutes  = min_q;
    assign hours    = hr_q;
    assign running  = running_q;
    assign sec_tick = sec_tick_q;
    assign expired  = expired_q;

endmodule
